// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate generator:
// instruction in, decoded immediate out.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic            out_illegal;
    logic [CW-1:0]   out_count;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm,
        input  out_type, out_illegal, out_count
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm,
        output out_type, out_illegal, out_count
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator with a small
// output FIFO so decode can stall apart from fetch.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input logic          CLK,
    input logic          RST_N,
    imm_gen_pipe_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = XLEN + 4;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          rdy_en;
    logic [EW-1:0] last;
    logic          push;
    logic          pop;
    logic [31:0]   ins;
    logic [31:0]   imm32;
    logic [2:0]    typ;
    logic          ill;
    logic [EW-1:0] entry;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // rdy_en keeps in_ready low until the first edge out of reset
    assign bus.in_ready  = rdy_en && (count < FULL);
    assign bus.out_valid = (count != '0);
    assign bus.out_count = count;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    assign ins  = bus.in_instr;

    // empty buffer shows the last popped result
    assign {bus.out_illegal, bus.out_type, bus.out_imm} =
        bus.out_valid ? mem[head] : last;

    // opcode decode; every legal opcode ends in 2'b11
    always_comb begin
        imm32 = '0;
        typ   = T_NONE;
        ill   = 1'b0;
        unique case (ins[6:0])
            7'b0110111, 7'b0010111: begin
                typ   = T_U;
                imm32 = {ins[31:12], 12'b0};
            end
            7'b1101111: begin
                typ   = T_J;
                imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                         ins[20], ins[30:21], 1'b0};
            end
            7'b1100011: begin
                typ   = T_B;
                imm32 = {{19{ins[31]}}, ins[31], ins[7],
                         ins[30:25], ins[11:8], 1'b0};
            end
            7'b0100011: begin
                typ   = T_S;
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100111, 7'b0000011,
            7'b0010011, 7'b0001111: begin
                typ   = T_I;
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            7'b1110011: begin
                if (ins[14]) begin
                    typ   = T_Z;
                    imm32 = {27'b0, ins[19:15]};
                end else begin
                    typ   = T_I;
                    imm32 = {{20{ins[31]}}, ins[31:20]};
                end
            end
            7'b0110011: begin
                typ = T_NONE;
            end
            default: begin
                ill = 1'b1;
            end
        endcase
    end

    // Z keeps bit 31 clear, so one sign-extend serves all formats
    assign entry = {ill, typ, XLEN'($signed(imm32))};

    // pointers, occupancy and the held last result
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rdy_en <= 1'b0;
            last   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (push) tail <= nxt(tail);
            if (pop) begin
                head <= nxt(head);
                last <= mem[head];
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // buffer storage
    always_ff @(posedge CLK) begin
        if (push) mem[tail] <= entry;
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 copies
// run in lockstep against a queue-based model.
module tb_imm_gen_pipe;
    localparam int DEPTH = 2;

    typedef struct {
        logic [63:0] imm;
        int          typ;
        bit          ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm;
        int          typ;
        bit          ill;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        iv;
    logic [31:0] ins;
    logic        ordy;

    int checks   = 0;
    int failures = 0;

    exp_t q[$];
    exp_t last;
    bit   armed;

    imm_gen_pipe_if #(.XLEN(32), .DEPTH(DEPTH)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .DEPTH(DEPTH)) b64 ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (b32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (b64)
    );

    assign b32.in_valid  = iv;
    assign b32.in_instr  = ins;
    assign b32.out_ready = ordy;
    assign b64.in_valid  = iv;
    assign b64.in_instr  = ins;
    assign b64.out_ready = ordy;

    always #5 CLK = ~CLK;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // immediate from field arithmetic on a sign-extended word
    function automatic exp_t model(logic [31:0] i);
        exp_t   e;
        longint sx;
        sx = longint'($signed(i));
        e  = '{64'h0, 0, 1'b0};
        case (i[6:0])
            7'b0110111, 7'b0010111: begin
                e.typ = 4;
                e.imm = (sx >>> 12) <<< 12;
            end
            7'b1101111: begin
                e.typ = 5;
                e.imm = ((sx >>> 31) <<< 20)
                      | (longint'(i[19:12]) <<< 12)
                      | (longint'(i[20]) <<< 11)
                      | (longint'(i[30:21]) <<< 1);
            end
            7'b1100011: begin
                e.typ = 3;
                e.imm = ((sx >>> 31) <<< 12)
                      | (longint'(i[7]) <<< 11)
                      | (longint'(i[30:25]) <<< 5)
                      | (longint'(i[11:8]) <<< 1);
            end
            7'b0100011: begin
                e.typ = 2;
                e.imm = ((sx >>> 25) <<< 5) | longint'(i[11:7]);
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: begin
                e.typ = 1;
                e.imm = sx >>> 20;
            end
            7'b1110011: begin
                if (i[14]) begin
                    e.typ = 6;
                    e.imm = longint'(i[19:15]);
                end else begin
                    e.typ = 1;
                    e.imm = sx >>> 20;
                end
            end
            7'b0110011: e.typ = 0;
            default:    e.ill = 1'b1;
        endcase
        return e;
    endfunction

    always @(negedge RST_N) begin
        q.delete();
        last  = '{64'h0, 0, 1'b0};
        armed = 1'b0;
    end

    // model update on each active edge
    always @(posedge CLK) begin
        if (RST_N) begin
            bit pu;
            bit po;
            po = (q.size() != 0) && ordy;
            pu = iv && armed && (q.size() < DEPTH);
            if (po) begin
                last = q[0];
                void'(q.pop_front());
            end
            if (pu) q.push_back(model(ins));
            armed = 1'b1;
        end
    end

    // per-cycle comparison of both DUTs against the model
    always @(negedge CLK) begin
        exp_t e;
        e = (q.size() != 0) ? q[0] : last;
        chk("cmp_valid32", b32.out_valid, 64'(q.size() != 0));
        chk("cmp_valid64", b64.out_valid, 64'(q.size() != 0));
        chk("cmp_count32", b32.out_count, 64'(q.size()));
        chk("cmp_count64", b64.out_count, 64'(q.size()));
        chk("cmp_ready32", b32.in_ready,
            64'(armed && (q.size() < DEPTH)));
        chk("cmp_ready64", b64.in_ready,
            64'(armed && (q.size() < DEPTH)));
        chk("cmp_imm32", b32.out_imm, {32'h0, e.imm[31:0]});
        chk("cmp_imm64", b64.out_imm, e.imm);
        chk("cmp_type32", b32.out_type, 64'(e.typ));
        chk("cmp_type64", b64.out_type, 64'(e.typ));
        chk("cmp_ill32", b32.out_illegal, 64'(e.ill));
        chk("cmp_ill64", b64.out_illegal, 64'(e.ill));
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // hand-computed expectation for the head of both DUTs
    task automatic lit(string nm, logic [63:0] e64, int t, bit il);
        chk({nm, "_valid"}, b32.out_valid, 64'd1);
        chk({nm, "_imm32"}, b32.out_imm, {32'h0, e64[31:0]});
        chk({nm, "_imm64"}, b64.out_imm, e64);
        chk({nm, "_type32"}, b32.out_type, 64'(t));
        chk({nm, "_type64"}, b64.out_type, 64'(t));
        chk({nm, "_ill"}, b32.out_illegal, 64'(il));
    endtask

    vec_t vt [9];

    initial begin
        vt[0] = '{32'h00000000, 64'h0, 0, 1'b1};
        vt[1] = '{32'h0000007F, 64'h0, 0, 1'b1};
        vt[2] = '{32'h00005073, 64'h0, 6, 1'b0};
        vt[3] = '{32'h000FD073, 64'd31, 6, 1'b0};
        vt[4] = '{32'h00000033, 64'h0, 0, 1'b0};
        vt[5] = '{32'h0000000F, 64'h0, 1, 1'b0};
        vt[6] = '{32'h80002073, 64'hFFFFFFFFFFFFF800, 1, 1'b0};
        vt[7] = '{32'h800002B7, 64'hFFFFFFFF80000000, 4, 1'b0};
        vt[8] = '{32'h7FFFF06F, 64'h00000000000FFFFE, 5, 1'b0};

        RST_N = 1'b1;
        iv    = 1'b0;
        ins   = '0;
        ordy  = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("rst_valid", b32.out_valid, 64'd0);
        chk("rst_count", b32.out_count, 64'd0);
        chk("rst_imm", b64.out_imm, 64'd0);
        chk("rst_type", b32.out_type, 64'd0);
        chk("rst_ill", b32.out_illegal, 64'd0);
        chk("rst_ready", b32.in_ready, 64'd0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        step();
        chk("rdy_after_rst", b32.in_ready, 64'd1);

        iv   = 1'b1;
        ins  = 32'hFFF00093;
        ordy = 1'b1;
        step();
        iv = 1'b0;
        lit("addi", 64'hFFFFFFFFFFFFFFFF, 1, 1'b0);
        step();
        chk("addi_drain", b32.out_valid, 64'd0);
        chk("addi_hold", b32.out_imm, 64'hFFFFFFFF);

        iv  = 1'b1;
        ins = 32'hFE112E23;
        step();
        lit("sw", 64'hFFFFFFFFFFFFFFFC, 2, 1'b0);
        ins = 32'h00000463;
        step();
        lit("beq", 64'h8, 3, 1'b0);
        ins = 32'h123452B7;
        step();
        lit("lui", 64'h12345000, 4, 1'b0);
        iv = 1'b0;
        step();
        chk("b2b_drain", b32.out_valid, 64'd0);

        ordy = 1'b0;
        iv   = 1'b1;
        ins  = 32'h00100093;
        step();
        chk("full_c1", b32.out_count, 64'd1);
        chk("full_r1", b32.in_ready, 64'd1);
        ins = 32'hFE112E23;
        step();
        chk("full_c2", b32.out_count, 64'd2);
        chk("full_r2", b32.in_ready, 64'd0);
        ins = 32'h00000463;
        step();
        chk("full_hold_c", b32.out_count, 64'd2);
        chk("full_hold_r", b32.in_ready, 64'd0);
        chk("full_head", b32.out_imm, 64'd1);
        step();
        chk("full_head2", b32.out_imm, 64'd1);
        ordy = 1'b1;
        step();
        chk("drain_c1", b32.out_count, 64'd1);
        chk("drain_h1", b32.out_imm, 64'hFFFFFFFC);
        step();
        chk("drain_c2", b32.out_count, 64'd1);
        chk("drain_h2", b32.out_imm, 64'h8);
        iv = 1'b0;
        step();
        chk("drain_c3", b32.out_count, 64'd0);

        foreach (vt[k]) begin
            iv  = 1'b1;
            ins = vt[k].ins;
            step();
            lit($sformatf("vec%0d", k), vt[k].imm, vt[k].typ, vt[k].ill);
        end
        iv = 1'b0;
        step();

        ordy = 1'b0;
        iv   = 1'b1;
        ins  = 32'h00100093;
        step();
        ins = 32'h00200093;
        step();
        iv = 1'b0;
        chk("mid_pre_c", b32.out_count, 64'd2);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_valid32", b32.out_valid, 64'd0);
        chk("mid_count32", b32.out_count, 64'd0);
        chk("mid_valid64", b64.out_valid, 64'd0);
        chk("mid_count64", b64.out_count, 64'd0);
        chk("mid_imm", b64.out_imm, 64'd0);
        #2 RST_N = 1'b1;
        step();
        chk("mid_rdy", b32.in_ready, 64'd1);
        iv   = 1'b1;
        ins  = 32'h00300093;
        ordy = 1'b1;
        step();
        iv = 1'b0;
        lit("post_rst", 64'd3, 1, 1'b0);
        step();
        chk("post_rst_drain", b32.out_valid, 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
